assert_monitor: RTL

Synthesizable, parametrised runtime checker. It replaces per-site simulation-only assert macros with a registered, multi-channel monitor, so on-chip logic and testbenches share one failure record. Each channel checks two things: a safety condition (cond must be true and known while enabled) and a liveness window (done must follow arm within TIMEOUT cycles). The block keeps sticky per-channel failure flags, saturating failure counts, and a first-failure record with a cycle timestamp. It sits beside the core and memory controller, and its outputs are readable by the debug/status path.

---
 rtl/assert_monitor.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/assert_monitor.sv
// assert_monitor: registered multi-channel safety/liveness checker.
// Keeps sticky per-channel failure flags, saturating counts and a first-fail record.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en, cond      per-channel safety enable and condition (cond must be 1 when enabled)
//   arm, done     per-channel liveness start / satisfy strobes
//   clr           clear flags, counts and first-fail record
//   fail_any      OR of fail_vec
//   fail_vec      sticky per-channel failure flags
//   first_ch      channel of first recorded failure
//   first_kind    0 none, 1 cond false, 2 cond unknown, 3 timeout
//   first_ts      cycle counter value when the first failure was sampled
//   fail_cnt      per-channel saturating counts, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   cyc           free-running cycle counter
module assert_monitor #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 8,
    parameter int TS_WIDTH  = 32,
    parameter int TIMEOUT   = 16,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int WC_W     = $clog2(TIMEOUT + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           en,
    input  logic [NUM_CH-1:0]           cond,
    input  logic [NUM_CH-1:0]           arm,
    input  logic [NUM_CH-1:0]           done,
    input  logic                        clr,
    output logic                        fail_any,
    output logic [NUM_CH-1:0]           fail_vec,
    output logic [CH_W-1:0]             first_ch,
    output logic [1:0]                  first_kind,
    output logic [TS_WIDTH-1:0]         first_ts,
    output logic [NUM_CH*CNT_WIDTH-1:0] fail_cnt,
    output logic [TS_WIDTH-1:0]         cyc
);

    typedef enum logic {IDLE, WAIT} lv_state_t;

    lv_state_t             st   [NUM_CH];
    logic [WC_W-1:0]       wcnt [NUM_CH];
    logic [1:0]            kind [NUM_CH];

    logic [NUM_CH-1:0]           ev;
    logic [NUM_CH-1:0]           vec_nxt;
    logic [NUM_CH*CNT_WIDTH-1:0] cnt_nxt;
    logic [CH_W-1:0]             sel_ch;
    logic [1:0]                  sel_kind;
    logic                        cap;

    // Per-channel event classification; priority 2 > 1 > 3.
    always_comb begin
        logic en_on;
        logic c_x;
        logic k1;
        logic k2;
        logic to;
        for (int i = 0; i < NUM_CH; i++) begin
`ifndef SYNTHESIS
            // An unknown enable is treated as asserted.
            en_on = (en[i] !== 1'b0);
            c_x   = $isunknown(cond[i]);
`else
            en_on = en[i];
            c_x   = 1'b0;
`endif
            k2 = en_on && c_x;
            k1 = en_on && !c_x && (cond[i] == 1'b0);
            to = (st[i] == WAIT) && !done[i] &&
                 (wcnt[i] == WC_W'(TIMEOUT));
            if (k2)      kind[i] = 2'd2;
            else if (k1) kind[i] = 2'd1;
            else if (to) kind[i] = 2'd3;
            else         kind[i] = 2'd0;
            ev[i] = (kind[i] != 2'd0);
        end
    end

    // Next flags/counts with clear applied before this cycle's events.
    always_comb begin
        logic [CNT_WIDTH-1:0] base;
        vec_nxt = (clr ? '0 : fail_vec) | ev;
        cnt_nxt = '0;
        base    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            base = clr ? '0 : fail_cnt[i*CNT_WIDTH +: CNT_WIDTH];
            if (ev[i] && (base != '1))
                base = base + CNT_WIDTH'(1);
            cnt_nxt[i*CNT_WIDTH +: CNT_WIDTH] = base;
        end
    end

    // Lowest-index failing channel wins the first-fail record.
    always_comb begin
        sel_ch   = '0;
        sel_kind = 2'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ev[i]) begin
                sel_ch   = CH_W'(i);
                sel_kind = kind[i];
            end
        end
        cap = (sel_kind != 2'd0) && (clr || (first_kind == 2'd0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc        <= '0;
            fail_any   <= 1'b0;
            fail_vec   <= '0;
            fail_cnt   <= '0;
            first_ch   <= '0;
            first_kind <= 2'd0;
            first_ts   <= '0;
        end else begin
            cyc      <= cyc + TS_WIDTH'(1);
            fail_vec <= vec_nxt;
            fail_any <= |vec_nxt;
            fail_cnt <= cnt_nxt;
            if (clr) begin
                first_ch   <= '0;
                first_kind <= 2'd0;
                first_ts   <= '0;
            end
            if (cap) begin
                first_ch   <= sel_ch;
                first_kind <= sel_kind;
                first_ts   <= cyc;
            end
        end
    end

    // Liveness FSMs; arm in WAIT never restarts the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                st[i]   <= IDLE;
                wcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                unique case (st[i])
                    IDLE: begin
                        if (arm[i] && !done[i]) begin
                            st[i]   <= WAIT;
                            wcnt[i] <= WC_W'(1);
                        end
                    end
                    WAIT: begin
                        if (done[i])
                            st[i] <= IDLE;
                        else if (wcnt[i] == WC_W'(TIMEOUT))
                            st[i] <= IDLE;
                        else
                            wcnt[i] <= wcnt[i] + WC_W'(1);
                    end
                    default: st[i] <= IDLE;
                endcase
            end
        end
    end

endmodule
